// File: rtl/b2_divider_sequencer.sv
// Sequential restoring divider: one quotient digit per clock, built on a
// reused (N+1)-digit ripple-borrow subtractor, with a start/done handshake.

module b2_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module b2_divider_sequencer #(
    parameter int unsigned N = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    rem_q;
    logic [N-1:0]    qsh_q;
    logic [N-1:0]    ysh_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    q_q;
    logic [N-1:0]    r_q;
    logic            dz_q;
    logic            busy_q;
    logic            done_q;

    logic [N:0]      t_c;
    logic [N:0]      ysub_c;
    logic [N:0]      diff_c;
    logic [N+1:0]    borrow_c;
    logic            bout_c;
    logic [N-1:0]    rem_d;
    logic [N-1:0]    qsh_d;
    logic            unused_top_c;

    // Trial subtraction of the divisor from the shifted partial remainder
    assign t_c         = {rem_q, qsh_q[N-1]};
    assign ysub_c      = {1'b0, ysh_q};
    assign borrow_c[0] = 1'b0;

    for (genvar i = 0; i <= N; i++) begin : g_cell
        b2_subtractor u_cell (
            .a    (t_c[i]),
            .b    (ysub_c[i]),
            .bin  (borrow_c[i]),
            .d    (diff_c[i]),
            .bout (borrow_c[i+1])
        );
    end

    assign bout_c = borrow_c[N+1];
    // Top difference digit is always zero when no borrow occurs
    assign unused_top_c = diff_c[N];

    assign rem_d = bout_c ? t_c[N-1:0] : diff_c[N-1:0];
    assign qsh_d = {qsh_q[N-2:0], ~bout_c};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            qsh_q   <= '0;
            ysh_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (y != '0) begin
                            rem_q   <= '0;
                            qsh_q   <= x;
                            ysh_q   <= y;
                            cnt_q   <= CW'(N - 1);
                            state_q <= RUN;
                        end else begin
                            q_q     <= '1;
                            r_q     <= x;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    qsh_q <= qsh_d;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        q_q     <= qsh_d;
                        r_q     <= rem_d;
                        dz_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_b2_divider_sequencer.sv
// Self-checking bench for b2_divider_sequencer against an arithmetic
// division model (x div y, x mod y, divide-by-zero convention).

module tb_b2_divider_sequencer;

    localparam int unsigned N = 3;
    localparam int unsigned MAXV = (1 << N) - 1;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;

    int total = 0;
    int bad   = 0;

    b2_divider_sequencer #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    always #5 clock = ~clock;

    function automatic void model(input int xa, input int ya,
                                  output int eq, output int er, output int edz, output int elat);
        if (ya == 0) begin
            eq = MAXV; er = xa; edz = 1; elat = 0;
        end else begin
            eq = xa / ya; er = xa % ya; edz = 0; elat = N;
        end
    endfunction

    // Issue one operation and collect what the DUT shows; checking is left to callers.
    task automatic do_op(input int xa, input int ya,
                         output int lat, output logic got_done,
                         output logic [N-1:0] qo, output logic [N-1:0] ro, output logic dzo,
                         output logic tail_ok, output logic held, output logic busy_ok);
        logic [N-1:0] q0, r0;
        @(negedge clock);
        x = N'(xa); y = N'(ya); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; x = N'($urandom); y = N'($urandom);
        q0 = q; r0 = r; held = 1'b1; lat = 0; busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && lat < 4 * N) begin
            @(posedge clock); #1;
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b1 && (q !== q0 || r !== r0)) held = 1'b0;
        end
        got_done = (done === 1'b1);
        qo = q; ro = r; dzo = dz;
        @(posedge clock); #1;
        tail_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; x = 3'd7; y = 3'd2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            total++;
            if ({q, r, dz, busy, done} !== '0) begin
                bad++;
                $display("FAIL reset_hold: q=%0d r=%0d dz=%0b busy=%0b done=%0b, required all zero", q, r, dz, busy, done);
            end
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if ({q, r, dz, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_release: q=%0d r=%0d dz=%0b busy=%0b done=%0b, required all zero", q, r, dz, busy, done);
        end
    endtask

    task automatic check_op(input string name, input int xa, input int ya);
        int lat, eq, er, edz, elat;
        logic gd, dzo, tail, held, bok;
        logic [N-1:0] qo, ro;
        model(xa, ya, eq, er, edz, elat);
        do_op(xa, ya, lat, gd, qo, ro, dzo, tail, held, bok);
        total++;
        if (!gd || lat != elat) begin
            bad++;
            $display("FAIL %s_latency x=%0d y=%0d: done=%0b lat=%0d, required done lat=%0d", name, xa, ya, gd, lat, elat);
        end
        total++;
        if (qo !== N'(eq) || ro !== N'(er) || dzo !== 1'(edz)) begin
            bad++;
            $display("FAIL %s_result x=%0d y=%0d: q=%0d r=%0d dz=%0b, required q=%0d r=%0d dz=%0d", name, xa, ya, qo, ro, dzo, eq, er, edz);
        end
        total++;
        if (!tail || !held || !bok) begin
            bad++;
            $display("FAIL %s_handshake x=%0d y=%0d: tail_ok=%0b held=%0b busy_ok=%0b, required 1 1 1", name, xa, ya, tail, held, bok);
        end
    endtask

    task automatic test_basic();
        check_op("basic", 7, 2);
        check_op("basic", 5, 7);
    endtask

    task automatic test_div_zero();
        check_op("divzero", 6, 0);
        check_op("after_divzero", 6, 3);
    endtask

    task automatic test_ignored_start();
        int xa, ya, xb, yb, ndone, eq, er, edz, elat, lat;
        logic [N-1:0] qc, rc;
        xa = $urandom_range(0, MAXV); ya = $urandom_range(1, MAXV);
        xb = $urandom_range(0, MAXV); yb = $urandom_range(1, MAXV);
        qc = '0; rc = '0; ndone = 0;
        @(negedge clock);
        x = N'(xa); y = N'(ya); start = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < N + 1; c++) begin
            @(negedge clock);
            x = N'($urandom); y = N'($urandom); start = 1'b1;
            @(posedge clock); #1;
            if (done === 1'b1) begin
                ndone++; qc = q; rc = r;
            end
        end
        model(xa, ya, eq, er, edz, elat);
        total++;
        if (ndone != 1 || qc !== N'(eq) || rc !== N'(er)) begin
            bad++;
            $display("FAIL ignored_start x=%0d y=%0d: dones=%0d q=%0d r=%0d, required dones=1 q=%0d r=%0d", xa, ya, ndone, qc, rc, eq, er);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start_idle: busy=%0b, required 0", busy);
        end
        @(negedge clock);
        x = N'(xb); y = N'(yb);
        @(posedge clock); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL ignored_start_accept: busy=%0b, required 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 4 * N) begin
            @(posedge clock); #1;
            lat++;
        end
        model(xb, yb, eq, er, edz, elat);
        total++;
        if (done !== 1'b1 || lat != elat || q !== N'(eq) || r !== N'(er)) begin
            bad++;
            $display("FAIL ignored_start_next x=%0d y=%0d: done=%0b lat=%0d q=%0d r=%0d, required lat=%0d q=%0d r=%0d", xb, yb, done, lat, q, r, elat, eq, er);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_midrun();
        int ndone;
        check_op("pre_reset", 7, 2);
        @(negedge clock);
        x = 3'd7; y = 3'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock);
        reset = 1'b1;
        #1;
        total++;
        if ({q, r, dz, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_midrun: q=%0d r=%0d dz=%0b busy=%0b done=%0b, required all zero", q, r, dz, busy, done);
        end
        ndone = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        reset = 1'b0;
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun_nodone: dones=%0d busy=%0b, required 0 0", ndone, busy);
        end
        check_op("post_reset", 4, 3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++)
            check_op("random", $urandom_range(0, MAXV), $urandom_range(0, MAXV));
    endtask

    task automatic test_exhaustive();
        for (int xa = 0; xa <= MAXV; xa++)
            for (int ya = 0; ya <= MAXV; ya++)
                check_op("exhaustive", xa, ya);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_ignored_start();
        test_reset_midrun();
        test_random();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
